add_accum_pipe: RTL and testbench

- Next-generation arithmetic block: parametrised-width adder/subtractor with a persistent accumulator.
- Valid/ready handshakes on both sides; result and flags pass through a configurable-depth register pipeline.
- Sits between the pin-level input muxing (operands A/B) and the output pins; replaces the fixed 8-bit registered adder.

---
 rtl/add_accum_pkg.sv | 26 ++
 rtl/add_accum_if.sv | 33 +++
 rtl/add_accum_stage.sv | 30 +++
 rtl/add_accum_pipe.sv | 118 +++++++++++
 tb/tb_add_accum_pipe.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/add_accum_pkg.sv
// add_accum_pipe shared types: opcodes, flag bundle, result beat.
// The default beat_t is sized for the legacy 8-bit datapath.
package add_accum_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
  } flags_t;

  localparam int unsigned W_DEF = 8;

  typedef struct packed {
    logic             valid;
    logic [W_DEF-1:0] y;
    flags_t           flags;
  } beat_t;

endpackage

// File: rtl/add_accum_if.sv
// add_accum_pipe operand/result handshake bundle.
// slave = arithmetic block side, master = producer/consumer side.
interface add_accum_if #(
  parameter int unsigned W = 8
);
  import add_accum_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  op_e          op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         carry;
  logic         ovf;
  logic         zero;
  logic [W-1:0] acc_q;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y,
    output carry, ovf, zero, acc_q
  );

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y,
    input  carry, ovf, zero, acc_q
  );

endinterface

// File: rtl/add_accum_stage.sv
// add_accum_pipe: one enable-gated result-beat register.
// Synchronous active-low reset clears the whole beat.
module add_accum_stage
  import add_accum_pkg::*;
#(
  parameter type T = beat_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  T     d_i,
  output T     q_o
);

  T beat_q;
  T beat_d;

  always_comb begin
    beat_d = beat_q;
    if (en) beat_d = d_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) beat_q <= '0;
    else        beat_q <= beat_d;
  end

  assign q_o = beat_q;

endmodule

// File: rtl/add_accum_pipe.sv
// add_accum_pipe: W-bit add/sub/accumulate with STAGES-deep result pipe.
// Define ADD_ACCUM_SATURATE_EN for unsigned saturation of the result.
module add_accum_pipe
  import add_accum_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned STAGES = 1
) (
  input logic      clk,
  input logic      rst_n,
  add_accum_if.slave bus
);

  typedef struct packed {
    logic         valid;
    logic [W-1:0] y;
    flags_t       flags;
  } beat_w_t;

  logic         adv;
  logic         accept;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         cin;
  logic [W:0]   sum;
  logic [W-1:0] res;
  flags_t       fl;
  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;
  beat_w_t      s_in;
  beat_w_t      s_q [STAGES];

  // The whole pipe moves as one; a stalled tail freezes every stage.
  assign adv    = !s_q[STAGES-1].valid || bus.out_ready;
  assign accept = bus.in_valid && adv;

  always_comb begin
    opa = bus.a;
    opb = bus.b;
    cin = 1'b0;
    unique case (1'b1)
      (bus.op == OP_SUB): begin
        opb = ~bus.b;
        cin = 1'b1;
      end
      (bus.op == OP_ACC): begin
        opa = acc_q;
        opb = bus.a;
      end
      (bus.op == OP_LOAD): opb = '0;
      default: ;
    endcase
    sum = {1'b0, opa} + {1'b0, opb} + {{W{1'b0}}, cin};
  end

  always_comb begin
    res      = sum[W-1:0];
    fl.carry = sum[W];
    fl.ovf   = (opa[W-1] == opb[W-1]) &&
               (res[W-1] != opa[W-1]);
    if (bus.op == OP_SUB) fl.carry = !sum[W];
    if (bus.op == OP_LOAD) begin
      fl.carry = 1'b0;
      fl.ovf   = 1'b0;
    end
`ifdef ADD_ACCUM_SATURATE_EN
    // Flags keep the raw condition; only y is clamped.
    if (fl.carry) res = (bus.op == OP_SUB) ? '0 : '1;
`endif
    fl.zero = (res == '0);
  end

  always_comb begin
    acc_d = acc_q;
    if (accept && (bus.op == OP_ACC || bus.op == OP_LOAD))
      acc_d = res;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  always_comb begin
    s_in.valid = accept;
    s_in.y     = res;
    s_in.flags = fl;
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_pipe
    if (i == 0) begin : g_first
      add_accum_stage #(.T(beat_w_t)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv),
        .d_i   (s_in),
        .q_o   (s_q[i])
      );
    end else begin : g_next
      add_accum_stage #(.T(beat_w_t)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv),
        .d_i   (s_q[i-1]),
        .q_o   (s_q[i])
      );
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = s_q[STAGES-1].valid;
  assign bus.y         = s_q[STAGES-1].y;
  assign bus.carry     = s_q[STAGES-1].flags.carry;
  assign bus.ovf       = s_q[STAGES-1].flags.ovf;
  assign bus.zero      = s_q[STAGES-1].flags.zero;
  assign bus.acc_q     = acc_q;

endmodule

// File: tb/tb_add_accum_pipe.sv
// Self-checking bench for add_accum_pipe (W=8, STAGES=3).
// Honours ADD_ACCUM_SATURATE_EN in its reference model.
module tb_add_accum_pipe;
  import add_accum_pkg::*;

  localparam int unsigned W      = 8;
  localparam int unsigned STAGES = 3;
  localparam longint M    = longint'(1) << W;
  localparam longint SMAX = M / 2 - 1;
  localparam longint SMIN = -(M / 2);
`ifdef ADD_ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] y;
    logic         c;
    logic         v;
    logic         z;
    int           t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  add_accum_if #(.W(W)) bus ();

  add_accum_pipe #(.W(W), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           n_acc = 0;
  exp_t         q[$];
  logic [W-1:0] m_acc = '0;
  logic         held = 1'b0;
  logic [W-1:0] h_y;
  logic [2:0]   h_f;
  logic         got = 1'b0;
  exp_t         last;
  logic         lat_on = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input op_e op, input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic [W-1:0] acc);
    exp_t   e;
    longint x, yv, sx, sy, r, s;
    e.c = 1'b0;
    e.v = 1'b0;
    e.t = 0;
    case (op)
      OP_ACC:  begin x = longint'(acc); yv = longint'(a); end
      OP_LOAD: begin x = longint'(a);   yv = 0;           end
      default: begin x = longint'(a);   yv = longint'(b); end
    endcase
    sx = (x > SMAX) ? x - M : x;
    sy = (yv > SMAX) ? yv - M : yv;
    if (op == OP_SUB) begin
      r   = x - yv;
      s   = sx - sy;
      e.c = (x < yv);
    end else begin
      r   = x + yv;
      s   = sx + sy;
      e.c = (r >= M);
    end
    if (op != OP_LOAD) e.v = (s > SMAX) || (s < SMIN);
    r   = ((r % M) + M) % M;
    e.y = r[W-1:0];
    if (SAT && e.c) e.y = (op == OP_SUB) ? '0 : '1;
    e.z = (e.y == '0);
    return e;
  endfunction

  task automatic cycle(input logic iv, input op_e op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ordy);
    exp_t e;
    logic rdy;
    int   lat;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = ordy;
    #1;
    rdy = !bus.out_valid || ordy;
    chk("in_ready", bus.in_ready, rdy);
    chk("acc_q", bus.acc_q, m_acc);
    if (held) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_y", bus.y, h_y);
      chk("hold_flags", {bus.carry, bus.ovf, bus.zero}, h_f);
    end
    held = 1'b0;
    if (bus.out_valid) begin
      if (!ordy) begin
        held = 1'b1;
        h_y  = bus.y;
        h_f  = {bus.carry, bus.ovf, bus.zero};
      end else if (q.size() == 0) begin
        chk("spurious_beat", bus.out_valid, 0);
      end else begin
        e = q.pop_front();
        chk("y", bus.y, e.y);
        chk("carry", bus.carry, e.c);
        chk("ovf", bus.ovf, e.v);
        chk("zero", bus.zero, e.z);
        last.y = bus.y;
        last.c = bus.carry;
        last.v = bus.ovf;
        last.z = bus.zero;
        got    = 1'b1;
        lat    = cyc - e.t;
        if (lat_on) chk("latency", lat, STAGES);
      end
    end
    if (iv && rdy) begin
      e   = model(op, a, b, m_acc);
      e.t = cyc;
      q.push_back(e);
      n_acc++;
      if (op == OP_ACC || op == OP_LOAD) m_acc = e.y;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, OP_ADD, '0, '0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++)
      cycle(1'b0, OP_ADD, '0, '0, 1'b1);
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_flags", {bus.carry, bus.ovf, bus.zero}, 0);
    chk("rst_acc_q", bus.acc_q, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    q.delete();
    m_acc = '0;
    held  = 1'b0;
  endtask

  task automatic one(input string tag, input op_e op,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] ey, input logic [2:0] ef);
    got = 1'b0;
    cycle(1'b1, op, a, b, 1'b1);
    for (int i = 0; i < 20 && !got; i++)
      cycle(1'b0, OP_ADD, '0, '0, 1'b1);
    chk({tag, "_seen"}, got, 1);
    chk({tag, "_y"}, last.y, ey);
    chk({tag, "_flags"}, {last.c, last.v, last.z}, ef);
  endtask

  initial begin
    int start;
    bus.in_valid  = 1'b0;
    bus.op        = OP_ADD;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    do_reset();
    idle(2);

    // Directed arithmetic corners; flags are {carry, ovf, zero}.
    one("add_wrap", OP_ADD, 8'hFF, 8'h01,
        SAT ? 8'hFF : 8'h00, SAT ? 3'b100 : 3'b101);
    one("sub_borrow", OP_SUB, 8'h10, 8'h20,
        SAT ? 8'h00 : 8'hF0, SAT ? 3'b101 : 3'b100);
    one("add_ovf", OP_ADD, 8'h7F, 8'h01, 8'h80, 3'b010);
    one("add_sat", OP_ADD, 8'hF0, 8'h20,
        SAT ? 8'hFF : 8'h10, 3'b100);
    one("sub_sat", OP_SUB, 8'h01, 8'h02,
        SAT ? 8'h00 : 8'hFF, SAT ? 3'b101 : 3'b100);

    // Back-to-back accumulate chain.
    cycle(1'b1, OP_LOAD, 8'h05, 8'hAA, 1'b1);
    cycle(1'b1, OP_ACC, 8'h03, 8'h55, 1'b1);
    cycle(1'b1, OP_ACC, 8'hFC, 8'h00, 1'b1);
    drain();
    #2;
    chk("acc_chain", bus.acc_q, SAT ? 8'hFF : 8'h04);

    // Latency with the consumer always ready.
    lat_on = 1'b1;
    for (int i = 0; i < 8; i++)
      cycle(1'b1, op_e'($urandom_range(0, 3)), W'($urandom),
            W'($urandom), 1'b1);
    drain();
    lat_on = 1'b0;

    // Backpressure: consumer stalls on cycles 4..7 of the stream.
    start = n_acc;
    for (int k = 1; k <= 14; k++)
      cycle((n_acc - start) < 6, op_e'($urandom_range(0, 3)),
            W'($urandom), W'($urandom), !(k >= 4 && k <= 7));
    drain();
    chk("bp_accepted", n_acc - start, 6);

    // Reset in the middle of traffic.
    cycle(1'b1, OP_LOAD, 8'h55, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, OP_ADD, W'($urandom), W'($urandom), 1'b1);
    do_reset();
    idle(STAGES + 4);

    // Random traffic with random valid/ready.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, op_e'($urandom_range(0, 3)),
            W'($urandom), W'($urandom), $urandom_range(0, 3) != 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
